// File: rtl/ram_responder.sv
// Word-addressed scratch RAM with independent read and write handshakes.
// Reads pulse rvalid RD_LATENCY edges after accept and writes pulse wready WR_LATENCY edges after accept; requests are accepted only when that side is free.
module ram_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH      = 1024,
  parameter int          RD_LATENCY = 2,
  parameter int          WR_LATENCY = 1
) (
  input  logic        ram_clk,
  input  logic        ram_rst,
  input  logic [31:0] ram_raddr,
  input  logic        ram_ren,
  output logic [31:0] ram_rdata,
  output logic        ram_rvalid,
  input  logic [31:0] ram_waddr,
  input  logic [31:0] ram_wdata,
  input  logic        ram_wen,
  input  logic [3:0]  ram_sel,
  output logic        ram_wready,
  output logic        addr_err
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [31:0] SPAN        = 32'(4 * DEPTH);
  localparam logic [3:0]  RD_CNT_INIT = 4'(RD_LATENCY - 1);
  localparam logic [3:0]  WR_CNT_INIT = 4'(WR_LATENCY - 1);

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_t;

  logic [31:0] mem [DEPTH];

  rd_state_t   rd_state, rd_next;
  wr_state_t   wr_state, wr_next;
  logic [3:0]  rd_cnt, wr_cnt;
  logic [AW-1:0] rd_idx, wr_idx;
  logic        rd_ok, wr_ok;
  logic [31:0] wr_dat;
  logic [3:0]  wr_sel;

  logic [31:0] rd_offset, wr_offset;
  logic        rd_accept, wr_accept, rd_fire, wr_fire;

  assign rd_offset = ram_raddr - BASE_ADDR;
  assign wr_offset = ram_waddr - BASE_ADDR;

  // The response cycle doubles as an idle cycle so a held request streams at one per LATENCY+1.
  assign rd_accept = ram_ren && (rd_state == RD_IDLE || rd_state == RD_RESP);
  assign wr_accept = ram_wen && (wr_state == WR_IDLE || wr_state == WR_RESP);
  assign rd_fire   = (rd_state == RD_WAIT) && (rd_cnt == 4'd0);
  assign wr_fire   = (wr_state == WR_WAIT) && (wr_cnt == 4'd0);

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ram_ren) rd_next = RD_WAIT;
      RD_WAIT: if (rd_cnt == 4'd0) rd_next = RD_RESP;
      RD_RESP: rd_next = ram_ren ? RD_WAIT : RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (ram_wen) wr_next = WR_WAIT;
      WR_WAIT: if (wr_cnt == 4'd0) wr_next = WR_RESP;
      WR_RESP: wr_next = ram_wen ? WR_WAIT : WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge ram_clk or negedge ram_rst) begin
    if (!ram_rst) begin
      rd_state   <= RD_IDLE;
      rd_cnt     <= 4'd0;
      rd_idx     <= '0;
      rd_ok      <= 1'b0;
      ram_rdata  <= 32'd0;
      ram_rvalid <= 1'b0;
    end else begin
      rd_state   <= rd_next;
      ram_rvalid <= rd_fire;
      if (rd_accept) begin
        rd_idx <= rd_offset[AW+1:2];
        rd_ok  <= rd_offset < SPAN;
        rd_cnt <= RD_CNT_INIT;
      end else if (rd_state == RD_WAIT && rd_cnt != 4'd0) begin
        rd_cnt <= rd_cnt - 4'd1;
      end
      // Nonblocking read of mem gives read-before-write on a same-edge commit.
      if (rd_fire) ram_rdata <= rd_ok ? mem[rd_idx] : 32'hDEAD_BEEF;
    end
  end

  always_ff @(posedge ram_clk or negedge ram_rst) begin
    if (!ram_rst) begin
      wr_state   <= WR_IDLE;
      wr_cnt     <= 4'd0;
      wr_idx     <= '0;
      wr_ok      <= 1'b0;
      wr_dat     <= 32'd0;
      wr_sel     <= 4'd0;
      ram_wready <= 1'b0;
    end else begin
      wr_state   <= wr_next;
      ram_wready <= wr_fire;
      if (wr_accept) begin
        wr_idx <= wr_offset[AW+1:2];
        wr_ok  <= wr_offset < SPAN;
        wr_dat <= ram_wdata;
        wr_sel <= ram_sel;
        wr_cnt <= WR_CNT_INIT;
      end else if (wr_state == WR_WAIT && wr_cnt != 4'd0) begin
        wr_cnt <= wr_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge ram_clk or negedge ram_rst) begin
    if (!ram_rst) addr_err <= 1'b0;
    else addr_err <= addr_err | (rd_fire & ~rd_ok) | (wr_fire & ~wr_ok);
  end

  // Contents survive reset; an aborted write never reaches here because reset idles the FSM.
  always_ff @(posedge ram_clk) begin
    if (wr_fire && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_sel[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder with a response scoreboard.
module tb_ram_responder;
  localparam logic [31:0] BASE  = 32'h0400_0000;
  localparam int          DEPTH = 16;
  localparam int          RL    = 2;
  localparam int          WL    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raddr, waddr, wdata, rdata;
  logic        ren, wen, rvalid, wready, addr_err;
  logic [3:0]  sel;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  int          wr_q[$];
  logic [31:0] model [DEPTH];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;

  ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LATENCY(RL), .WR_LATENCY(WL)) dut (
    .ram_clk(clk), .ram_rst(rst),
    .ram_raddr(raddr), .ram_ren(ren), .ram_rdata(rdata), .ram_rvalid(rvalid),
    .ram_waddr(waddr), .ram_wdata(wdata), .ram_wen(wen), .ram_sel(sel),
    .ram_wready(wready), .addr_err(addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return in_rng(a) ? model[widx(a)] : 32'hDEAD_BEEF;
  endfunction

  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      rd_pulses++;
      check("rd_pending", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check("rd_data", rdata, e.dat);
        check("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (wready === 1'b1) begin
      wr_pulses++;
      check("wr_pending", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) check("wr_cycle", 32'(cyc), 32'(wr_q.pop_front()));
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_q.push_back(cyc + 1 + WL);
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
    end
    waddr = a; wdata = d; sel = s; wen = 1'b1;
    step();
    wen = 1'b0; waddr = $urandom; wdata = $urandom; sel = 4'($urandom);
    repeat (WL + 1) step();
  endtask

  task automatic do_read(input logic [31:0] a);
    rd_exp_t e;
    e.dat = exp_rd(a);
    e.cyc = cyc + 1 + RL;
    rd_q.push_back(e);
    raddr = a; ren = 1'b1;
    step();
    ren = 1'b0; raddr = $urandom;
    repeat (RL + 1) step();
  endtask

  initial begin
    int p, c;
    rd_exp_t e;
    rst = 1'b1; ren = 1'b0; wen = 1'b0; raddr = '0; waddr = '0; wdata = '0; sel = '0;
    #2 rst = 1'b0;

    // Reset held: requests must be ignored.
    for (int i = 0; i < 4; i++) begin
      step();
      ren = ~ren; wen = ~wen; raddr = BASE + 32'(4 * DEPTH); waddr = raddr; sel = 4'hF;
      @(negedge clk);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_addr_err", 32'(addr_err), 32'd0);
    end
    step();
    ren = 1'b0; wen = 1'b0;
    step();
    rst = 1'b1;
    step();

    do_write(BASE + 32'h10, 32'h1234_5678, 4'hF);
    do_read(BASE + 32'h10);

    do_write(BASE + 32'h20, 32'hAABB_CCDD, 4'hF);
    do_write(BASE + 32'h20, 32'h1122_3344, 4'b0101);
    check("model_bytes", model[8], 32'hAA22_CC44);
    do_read(BASE + 32'h20);
    p = wr_pulses;
    do_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'b0000);
    check("sel0_pulses", 32'(wr_pulses - p), 32'd1);
    do_read(BASE + 32'h22);

    // Held ren: second request accepted on the response cycle.
    do_write(BASE, 32'hA0A0_A0A0, 4'hF);
    do_write(BASE + 32'h4, 32'hB4B4_B4B4, 4'hF);
    p = rd_pulses; c = cyc;
    e.dat = model[0]; e.cyc = c + 1 + RL; rd_q.push_back(e);
    e.dat = model[1]; e.cyc = c + 2 + 2 * RL; rd_q.push_back(e);
    raddr = BASE; ren = 1'b1;
    step();
    raddr = BASE + 32'h4;
    repeat (5) step();
    ren = 1'b0;
    repeat (4) step();
    check("stream_pulses", 32'(rd_pulses - p), 32'd2);
    @(negedge clk);
    check("rdata_hold", rdata, 32'hB4B4_B4B4);
    check("err_clear", 32'(addr_err), 32'd0);

    do_read(BASE + 32'(4 * DEPTH));
    @(negedge clk);
    check("err_set", 32'(addr_err), 32'd1);
    do_write(BASE + 32'(4 * DEPTH) + 32'h10, 32'h0, 4'hF);
    do_read(BASE + 32'h10);
    do_read(BASE - 32'h4);
    @(negedge clk);
    check("err_sticky", 32'(addr_err), 32'd1);

    // Read and write completing on the same edge see old data.
    do_write(BASE + 32'h30, 32'h5555_0000, 4'hF);
    c = cyc;
    e.dat = 32'h5555_0000; e.cyc = c + 1 + RL; rd_q.push_back(e);
    raddr = BASE + 32'h30; ren = 1'b1;
    step();
    ren = 1'b0;
    wr_q.push_back(c + 2 + WL);
    waddr = BASE + 32'h30; wdata = 32'h6666_7777; sel = 4'hF; wen = 1'b1;
    step();
    wen = 1'b0; wdata = $urandom;
    model[12] = 32'h6666_7777;
    repeat (3) step();
    do_read(BASE + 32'h30);

    // Reset during the read wait aborts the response.
    p = rd_pulses;
    raddr = BASE + 32'h10; ren = 1'b1;
    step();
    ren = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("abort_rvalid", 32'(rvalid), 32'd0);
    check("abort_err", 32'(addr_err), 32'd0);
    step();
    rst = 1'b1;
    repeat (4) step();
    check("abort_pulses", 32'(rd_pulses - p), 32'd0);
    do_read(BASE + 32'h10);

    repeat (3) step();
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
